bat_amateur_regbank: RTL and testbench

- Register-bank responder on the controller's register-strobe interface.
- Holds the general registers (A, B, 3..7) and the OUT register. Each register consumes its INC, RW and EN strobes.
- Loads registers from the shared bus, drives the bus when enabled, and increments in place.
- The OUT register also drives a valid/ready handshake toward the output device. The block flags bus contention and output overrun.

---
 rtl/bat_amateur_regbank.sv | 82 ++++++++
 tb/tb_bat_amateur_regbank.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bat_amateur_regbank.sv
// bat_amateur_regbank: register bank on the controller's INC/RW/EN strobes,
// with a shared bus, an output handshake register and sticky error flags.
module bat_amateur_regbank #(
    parameter int WIDTH   = 8,
    parameter int NREGS   = 8,
    parameter int OUT_IDX = NREGS - 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NREGS-1:0] REGS_INC,
    input  logic [NREGS-1:0] REGS_RW,
    input  logic [NREGS-1:0] REGS_EN,
    input  logic [WIDTH-1:0] BUS_IN,
    output logic [WIDTH-1:0] BUS_OUT,
    output logic             BUS_DRIVE,
    output logic             BUS_CONFLICT,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             OUT_OVERRUN,
    input  logic             CLR_ERR
);
    typedef enum logic {IDLE, FULL} state_t;

    logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
    state_t                      state_q, state_d;
    logic                        conflict_q, conflict_d;
    logic                        overrun_q, overrun_d;
    logic [NREGS-1:0]            drv, load;
    logic                        out_upd;

    assign drv  = REGS_EN & ~REGS_RW;
    assign load = REGS_EN & REGS_RW;
    assign out_upd = load[OUT_IDX] | REGS_INC[OUT_IDX];

    // Scan downward so the lowest-index driver is the last one written.
    always_comb begin
        BUS_OUT = '0;
        for (int i = NREGS - 1; i >= 0; i--)
            if (drv[i]) BUS_OUT = regs_q[i];
    end

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NREGS; i++)
            regs_d[i] = load[i] ? BUS_IN : REGS_INC[i] ? regs_q[i] + WIDTH'(1) : regs_q[i];
    end

    always_comb begin
        state_d    = state_q;
        overrun_d  = overrun_q & ~CLR_ERR;
        conflict_d = ((drv & (drv - NREGS'(1))) != '0) | (conflict_q & ~CLR_ERR);
        case (state_q)
            IDLE: state_d = out_upd ? FULL : IDLE;
            FULL: begin
                state_d   = (out_upd || !OUT_READY) ? FULL : IDLE;
                overrun_d = (out_upd & ~OUT_READY) | overrun_d;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            regs_q     <= '0;
            state_q    <= IDLE;
            conflict_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            state_q    <= state_d;
            conflict_q <= conflict_d;
            overrun_q  <= overrun_d;
        end
    end

    assign BUS_DRIVE    = |drv;
    assign BUS_CONFLICT = conflict_q;
    assign OUT_DATA     = regs_q[OUT_IDX];
    assign OUT_VALID    = (state_q == FULL);
    assign OUT_OVERRUN  = overrun_q;
endmodule

// File: tb/tb_bat_amateur_regbank.sv
// tb_bat_amateur_regbank: directed stimulus, a behavioural model compared every
// cycle, and literal expectations at the test-plan checkpoints.
module tb_bat_amateur_regbank;
    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] inc, rw, en, bin;
    logic       rdy, clr;
    logic [7:0] bus_out, out_data;
    logic       bus_drive, bus_conflict, out_valid, out_overrun;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m_regs [8];
    logic       m_valid, m_conflict, m_overrun;

    bat_amateur_regbank #(.WIDTH(8), .NREGS(8), .OUT_IDX(7)) dut (
        .CLK(CLK), .RST(RST), .REGS_INC(inc), .REGS_RW(rw), .REGS_EN(en),
        .BUS_IN(bin), .BUS_OUT(bus_out), .BUS_DRIVE(bus_drive),
        .BUS_CONFLICT(bus_conflict), .OUT_DATA(out_data), .OUT_VALID(out_valid),
        .OUT_READY(rdy), .OUT_OVERRUN(out_overrun), .CLR_ERR(clr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_valid = 0; m_conflict = 0; m_overrun = 0;
    endtask

    // Model: the lowest enabled, non-loading register wins the bus.
    function automatic logic [7:0] m_bus();
        for (int i = 0; i < 8; i++)
            if (en[i] && !rw[i]) return m_regs[i];
        return 8'h00;
    endfunction

    task automatic m_step();
        int  ndrv;
        bit  upd;
        ndrv = $countones(en & ~rw);
        upd  = (en[7] && rw[7]) || inc[7];
        m_conflict = (ndrv >= 2) || (m_conflict && !clr);
        m_overrun  = (m_valid && upd && !rdy) || (m_overrun && !clr);
        if (upd) m_valid = 1;
        else if (rdy) m_valid = 0;
        for (int i = 0; i < 8; i++) begin
            if (en[i] && rw[i]) m_regs[i] = bin;
            else if (inc[i]) m_regs[i] = 8'((int'(m_regs[i]) + 1) % 256);
        end
    endtask

    always @(posedge CLK or negedge RST)
        if (!RST) m_reset(); else m_step();

    always @(negedge CLK) begin
        #3;
        chk("bus_out", bus_out, m_bus());
        chk("bus_drive", bus_drive, (en & ~rw) != 0);
        chk("bus_conflict", bus_conflict, m_conflict);
        chk("out_data", out_data, m_regs[7]);
        chk("out_valid", out_valid, m_valid);
        chk("out_overrun", out_overrun, m_overrun);
    end

    task automatic cyc(input logic [7:0] i_inc, input logic [7:0] i_rw, input logic [7:0] i_en,
                       input logic [7:0] i_bus, input logic i_rdy, input logic i_clr);
        @(negedge CLK);
        inc = i_inc; rw = i_rw; en = i_en; bin = i_bus; rdy = i_rdy; clr = i_clr;
    endtask

    task automatic idle(input logic i_rdy);
        cyc(8'h00, 8'h00, 8'h00, 8'h00, i_rdy, 1'b0);
    endtask

    initial begin
        RST = 0; inc = 0; rw = 0; en = 0; bin = 0; rdy = 0; clr = 0;
        m_reset();
        // 1. reset
        #12;
        chk("rst_bus_out", bus_out, 0);
        chk("rst_bus_drive", bus_drive, 0);
        chk("rst_conflict", bus_conflict, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_overrun", out_overrun, 0);
        chk("rst_out_data", out_data, 0);
        @(negedge CLK); RST = 1;
        cyc(8'h00, 8'h00, 8'h01, 8'h00, 0, 0); #4;
        chk("t1_bus_out", bus_out, 8'h00);
        chk("t1_bus_drive", bus_drive, 1);
        // 2. load, drive, increment A
        cyc(8'h00, 8'h01, 8'h01, 8'h5A, 0, 0);
        cyc(8'h00, 8'h00, 8'h01, 8'h00, 0, 0); #4;
        chk("t2_drive_a", bus_out, 8'h5A);
        repeat (3) cyc(8'h01, 8'h00, 8'h00, 8'h00, 0, 0);
        cyc(8'h00, 8'h00, 8'h01, 8'h00, 0, 0); #4;
        chk("t2_inc_a", bus_out, 8'h5D);
        // 3. wrap on B, load beats increment
        cyc(8'h00, 8'h02, 8'h02, 8'hFE, 0, 0);
        repeat (2) cyc(8'h02, 8'h00, 8'h00, 8'h00, 0, 0);
        cyc(8'h00, 8'h00, 8'h02, 8'h00, 0, 0); #4;
        chk("t3_wrap_b", bus_out, 8'h00);
        cyc(8'h00, 8'h00, 8'h01, 8'h00, 0, 0); #4;
        chk("t3_a_untouched", bus_out, 8'h5D);
        cyc(8'h02, 8'h02, 8'h02, 8'h10, 0, 0);
        cyc(8'h00, 8'h00, 8'h02, 8'h00, 0, 0); #4;
        chk("t3_load_wins", bus_out, 8'h10);
        // 4. contention and CLR_ERR
        cyc(8'h00, 8'h01, 8'h01, 8'h11, 0, 0);
        cyc(8'h00, 8'h02, 8'h02, 8'h22, 0, 0);
        cyc(8'h00, 8'h00, 8'h03, 8'h00, 0, 0); #4;
        chk("t4_lowest_wins", bus_out, 8'h11);
        chk("t4_conflict_pre", bus_conflict, 0);
        idle(0); #4;
        chk("t4_conflict_set", bus_conflict, 1);
        idle(0); #4;
        chk("t4_conflict_sticky", bus_conflict, 1);
        cyc(8'h00, 8'h00, 8'h01, 8'h00, 0, 1);
        idle(0); #4;
        chk("t4_conflict_clr", bus_conflict, 0);
        cyc(8'h00, 8'h00, 8'h03, 8'h00, 0, 1);
        idle(0); #4;
        chk("t4_clr_loses", bus_conflict, 1);
        cyc(8'h00, 8'h00, 8'h00, 8'h00, 0, 1);
        // 5. OUT handshake
        cyc(8'h00, 8'h80, 8'h80, 8'h41, 0, 0);
        repeat (3) idle(0);
        #4;
        chk("t5_valid_hold", out_valid, 1);
        chk("t5_data_41", out_data, 8'h41);
        idle(1);
        idle(0); #4;
        chk("t5_accepted", out_valid, 0);
        cyc(8'h00, 8'h80, 8'h80, 8'h42, 0, 0);
        cyc(8'h00, 8'h80, 8'h80, 8'h43, 0, 0);
        idle(0); #4;
        chk("t5_data_43", out_data, 8'h43);
        chk("t5_overrun", out_overrun, 1);
        cyc(8'h00, 8'h00, 8'h00, 8'h00, 0, 1);
        cyc(8'h00, 8'h80, 8'h80, 8'h44, 1, 0);
        idle(0); #4;
        chk("t5_no_overrun", out_overrun, 0);
        chk("t5_still_valid", out_valid, 1);
        chk("t5_data_44", out_data, 8'h44);
        idle(1);
        cyc(8'h80, 8'h00, 8'h00, 8'h00, 0, 0);
        idle(0); #4;
        chk("t5_inc_valid", out_valid, 1);
        chk("t5_inc_data", out_data, 8'h45);
        // 6. asynchronous reset mid-operation
        cyc(8'h00, 8'h00, 8'h03, 8'h00, 0, 0);
        idle(0); #2;
        chk("t6_pre_conflict", bus_conflict, 1);
        RST = 0; #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_conflict", bus_conflict, 0);
        chk("t6_data", out_data, 0);
        #1 RST = 1;
        cyc(8'h00, 8'h00, 8'h01, 8'h00, 0, 0); #4;
        chk("t6_a_cleared", bus_out, 8'h00);
        repeat (3) idle(0);
        #4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
